icache_sa: RTL and testbench

Parametrised two-way set-associative instruction cache between the CPU fetch stage and the block-wide instruction memory. Replaces the fixed 8-set direct-mapped cache and adds configurable geometry, LRU replacement, and a whole-cache invalidate (`flush`) for OS context switches. Hits return the instruction combinationally in the same cycle. Misses stall the CPU through `busywait` while one block is fetched.

---
 rtl/icache_sa.sv | 143 ++++++++++++++
 tb/tb_icache_sa.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// Two-way set-associative instruction cache with LRU replacement and whole-cache flush.
// Optional perf counters (hit_count/miss_count) built when ICACHE_SA_PERF_EN is defined.
module icache_sa #(
    parameter int ADDR_WIDTH      = 32,
    parameter int SETS            = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        fetch,
    input  logic [ADDR_WIDTH-1:0]                       address,
    input  logic                                        flush,
    output logic [31:0]                                 instruction,
    output logic                                        busywait,
    output logic                                        mem_read,
    output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-3:0] mem_address,
    input  logic [32*WORDS_PER_BLOCK-1:0]               mem_readdata,
    input  logic                                        mem_busywait
`ifdef ICACHE_SA_PERF_EN
    ,
    output logic [31:0]                                 hit_count,
    output logic [31:0]                                 miss_count
`endif
);
    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int BLK_W  = 32 * WORDS_PER_BLOCK;
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;

    typedef enum logic [1:0] {IDLE, MEM_READ, FILL, FLUSH} state_t;

    state_t state, next;

    logic [1:0][SETS-1:0] valid;
    logic [SETS-1:0]      lru;
    logic [TAG_W-1:0]     tags   [2][SETS];
    logic [BLK_W-1:0]     data_q [2][SETS];
    logic [BLK_W-1:0]     blk_q;
    logic                 flush_pending;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_WS-1:0] offset;
    logic [1:0]        way_hit;
    logic              hit, hit_way, victim, flush_due;
    logic [BLK_W-1:0]  sel_blk;
    logic              unused;

    assign tag    = address[ADDR_WIDTH-1:IDX_W+OFF_W+2];
    assign idx    = address[IDX_W+OFF_W+1:OFF_W+2];
    assign unused = ^address[1:0];

    generate
        if (OFF_W > 0) begin : g_off
            assign offset = address[OFF_W+1:2];
        end else begin : g_nooff
            assign offset = '0;
        end
    endgenerate

    assign mem_address = address[ADDR_WIDTH-1:OFF_W+2];

    always_comb begin
        for (int w = 0; w < 2; w++)
            way_hit[w] = valid[w][idx] && (tags[w][idx] == tag);
    end

    assign hit       = fetch && (|way_hit);
    assign hit_way   = way_hit[1];
    assign sel_blk   = data_q[hit_way][idx];
    assign instruction = hit ? sel_blk[32*offset +: 32] : 32'd0;
    assign flush_due = flush || flush_pending;
    // Fill into an empty way first; only evict by LRU when the set is full.
    assign victim    = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

    always_comb begin
        next     = state;
        busywait = 1'b1;
        mem_read = 1'b0;
        case (state)
            IDLE: begin
                busywait = flush_due || (fetch && !hit);
                if (flush_due)          next = FLUSH;
                else if (fetch && !hit) next = MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) next = FILL;
            end
            FILL:    next = IDLE;
            FLUSH:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            lru           <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= next;
            case (state)
                IDLE: if (hit) lru[idx] <= ~hit_way;
                MEM_READ: if (flush) flush_pending <= 1'b1;
                FILL: begin
                    valid[victim][idx] <= 1'b1;
                    lru[idx]           <= ~victim;
                    if (flush) flush_pending <= 1'b1;
                end
                FLUSH: begin
                    valid         <= '0;
                    lru           <= '0;
                    flush_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clock) begin
        if (state == MEM_READ && !mem_busywait) blk_q <= mem_readdata;
        if (state == FILL && !reset) begin
            tags[victim][idx]   <= tag;
            data_q[victim][idx] <= blk_q;
        end
    end

`ifdef ICACHE_SA_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && hit)         hit_count  <= hit_count + 32'd1;
            if (state == IDLE && next == MEM_READ) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: table of fetches plus hand sequences for flush and reset.
module tb_icache_sa;
    logic         clock = 0;
    logic         reset, fetch, flush;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait, mem_read, mem_busywait;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
`ifdef ICACHE_SA_PERF_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int applied = 0;
    int errors  = 0;
    int lat     = 1;
    int mcnt;

    icache_sa dut (
        .clock(clock), .reset(reset), .fetch(fetch), .address(address), .flush(flush),
        .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
        .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef ICACHE_SA_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    // Memory: word at byte address a reads as 0xC000_0000 | a; answers on the lat-th cycle.
    always @(posedge clock) begin
        if (reset || !mem_read) mcnt <= 0;
        else                    mcnt <= mcnt + 1;
    end
    assign mem_busywait = !(mem_read && (mcnt >= lat - 1));
    always_comb begin
        mem_readdata = '0;
        for (int i = 0; i < 4; i++)
            mem_readdata[32*i +: 32] = 32'hC000_0000 | {mem_address, 4'b0} | (i * 4);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hold fetch until busywait drops; called and returns just after a rising edge.
    task automatic do_fetch(input logic [31:0] a, input int l, output int stalls, output int reads,
                            output logic [31:0] instr, output logic [31:0] maddr, output bit to);
        bit done = 0;
        lat = l; address = a; fetch = 1'b1;
        stalls = 0; reads = 0; instr = '0; maddr = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clock);
            if (!busywait) begin
                instr = instruction;
                done  = 1;
            end else begin
                stalls++;
                if (mem_read) begin
                    if (reads == 0) maddr = 32'(mem_address);
                    reads++;
                end
            end
            @(posedge clock); #1;
        end
        to = !done;
        fetch = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          lat;
        int          stalls;
        int          reads;
        logic [31:0] instr;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs [10];
    int          st, rd;
    logic [31:0] ins, ma;
    bit          to;

    task automatic run_check(input string name, input logic [31:0] a, input int l,
                             input int exp_st, input int exp_rd, input logic [31:0] exp_ins,
                             input logic [31:0] exp_ma);
        do_fetch(a, l, st, rd, ins, ma, to);
        check({name, "_timeout"}, 32'(to), 32'd0);
        check({name, "_stalls"}, 32'(st), 32'(exp_st));
        check({name, "_memreads"}, 32'(rd), 32'(exp_rd));
        check({name, "_instr"}, ins, exp_ins);
        if (exp_rd > 0) check({name, "_memaddr"}, ma, exp_ma);
    endtask

    initial begin
        vecs[0] = '{"cold_40",   32'h040, 5, 7, 5, 32'hC000_0040, 32'h4};
        vecs[1] = '{"hit_44",    32'h044, 1, 0, 0, 32'hC000_0044, 32'h0};
        vecs[2] = '{"hit_48",    32'h048, 1, 0, 0, 32'hC000_0048, 32'h0};
        vecs[3] = '{"hit_4c",    32'h04C, 1, 0, 0, 32'hC000_004C, 32'h0};
        vecs[4] = '{"fill_000",  32'h000, 2, 4, 2, 32'hC000_0000, 32'h0};
        vecs[5] = '{"fill_080",  32'h080, 1, 3, 1, 32'hC000_0080, 32'h8};
        vecs[6] = '{"touch_000", 32'h000, 1, 0, 0, 32'hC000_0000, 32'h0};
        vecs[7] = '{"evict_100", 32'h104, 1, 3, 1, 32'hC000_0104, 32'h10};
        vecs[8] = '{"keep_000",  32'h00C, 1, 0, 0, 32'hC000_000C, 32'h0};
        vecs[9] = '{"gone_080",  32'h088, 3, 5, 3, 32'hC000_0088, 32'h8};

        reset = 1'b1; fetch = 1'b0; flush = 1'b0; address = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_instr", instruction, 32'd0);
`ifdef ICACHE_SA_PERF_EN
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
`endif
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++)
            run_check(vecs[i].name, vecs[i].addr, vecs[i].lat, vecs[i].stalls,
                      vecs[i].reads, vecs[i].instr, vecs[i].maddr);

        // Flush with 0x000 cached: flush-due cycle, FLUSH cycle, then idle again.
        flush = 1'b1;
        @(negedge clock); check("flush_due_busy", 32'(busywait), 32'd1);
        @(posedge clock); #1 flush = 1'b0;
        @(negedge clock); check("flush_state_busy", 32'(busywait), 32'd1);
        @(posedge clock); #1;
        @(negedge clock); check("flush_done_idle", 32'(busywait), 32'd0);
`ifdef ICACHE_SA_PERF_EN
        check("flush_keeps_hits", hit_count, 32'd10);
        check("flush_keeps_misses", miss_count, 32'd5);
`endif
        @(posedge clock); #1;
        run_check("post_flush_000", 32'h000, 1, 3, 1, 32'hC000_0000, 32'h0);

        // Flush during MEM_READ: fill finishes, flush runs, same address misses again.
        fork
            do_fetch(32'h080, 3, st, rd, ins, ma, to);
            begin
                repeat (2) @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join
        check("defer_timeout", 32'(to), 32'd0);
        check("defer_stalls", 32'(st), 32'd12);
        check("defer_memreads", 32'(rd), 32'd6);
        check("defer_instr", ins, 32'hC000_0080);

        // Reset while a miss is outstanding.
        lat = 10; address = 32'h180; fetch = 1'b1;
        @(posedge clock); #1;
        @(negedge clock); check("midmiss_mem_read", 32'(mem_read), 32'd1);
        @(posedge clock); #1 reset = 1'b1; fetch = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_mem_read", 32'(mem_read), 32'd0);
        check("midrst_busywait", 32'(busywait), 32'd0);
        check("midrst_instr", instruction, 32'd0);
`ifdef ICACHE_SA_PERF_EN
        check("midrst_hits", hit_count, 32'd0);
        check("midrst_misses", miss_count, 32'd0);
`endif
        @(posedge clock); #1;
        run_check("midrst_080_miss", 32'h080, 1, 3, 1, 32'hC000_0080, 32'h8);
        run_check("hit_084", 32'h084, 1, 0, 0, 32'hC000_0084, 32'h0);
        run_check("hit_088", 32'h088, 1, 0, 0, 32'hC000_0088, 32'h0);
`ifdef ICACHE_SA_PERF_EN
        check("perf_hits", hit_count, 32'd3);
        check("perf_misses", miss_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
